// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared PE operand constants and 3x3 window packing order
package pe_pkg;

  localparam int PIX_W = 8;
  localparam int KSIZE = 3;
  localparam int WIN_W = KSIZE * KSIZE * PIX_W;

  // Window tap indices; tap 0 lands in the MSBs of the packed bus.
  localparam int W_TL = 0;
  localparam int W_TM = 1;
  localparam int W_TR = 2;
  localparam int W_ML = 3;
  localparam int W_MM = 4;
  localparam int W_MR = 5;
  localparam int W_BL = 6;
  localparam int W_BM = 7;
  localparam int W_BR = 8;

endpackage

// File: rtl/row_delay.sv
// rtl/row_delay.sv - enable-gated DEPTH-stage pixel delay line (one image row)
module row_delay #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are never reset: consumers only look at them after DEPTH fresh shifts.
  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/pe_window_feeder.sv
// rtl/pe_window_feeder.sv - raster pixel stream to registered 3x3 windows for one PE
module pe_window_feeder #(
  parameter int PIX_W = pe_pkg::PIX_W,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  input  logic [PIX_W-1:0]                      in_data,
  input  logic                                  flush,
  output logic [pe_pkg::KSIZE*pe_pkg::KSIZE*PIX_W-1:0] win_out,
  output logic                                  win_en,
  output logic                                  frame_done,
  output logic                                  busy
);
  import pe_pkg::*;

  localparam int NTAP     = KSIZE * KSIZE;
  localparam int WIN_BITS = NTAP * PIX_W;
  localparam int CW       = $clog2(IMG_W);
  localparam int RW       = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(KSIZE - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(KSIZE - 1);

  logic                accept;
  logic [PIX_W-1:0]    up1, up2;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic [WIN_BITS-1:0] win_out_q, win_out_d;
  logic                win_en_q, win_en_d;
  logic                frame_done_q, frame_done_d;
  logic [WIN_BITS-1:0] win_pack;
  logic [PIX_W-1:0]    tap [NTAP];

  // Per image row: [0] = column c-1, [1] = column c-2; index 0 is the oldest row.
  logic [1:0][PIX_W-1:0] hs_q [KSIZE];
  logic [1:0][PIX_W-1:0] hs_d [KSIZE];

  assign accept = in_valid && !flush;

  row_delay #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_row_delay_1 (
    .clk    (clk),
    .en_i   (accept),
    .din_i  (in_data),
    .dout_o (up1)
  );

  row_delay #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_row_delay_2 (
    .clk    (clk),
    .en_i   (accept),
    .din_i  (up1),
    .dout_o (up2)
  );

  always_comb begin
    tap[W_TL] = hs_q[0][1];
    tap[W_TM] = hs_q[0][0];
    tap[W_TR] = up2;
    tap[W_ML] = hs_q[1][1];
    tap[W_MM] = hs_q[1][0];
    tap[W_MR] = up1;
    tap[W_BL] = hs_q[2][1];
    tap[W_BM] = hs_q[2][0];
    tap[W_BR] = in_data;
    win_pack = '0;
    for (int k = 0; k < NTAP; k++) begin
      win_pack[WIN_BITS-1-k*PIX_W -: PIX_W] = tap[k];
    end
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    hs_d         = hs_q;
    win_out_d    = win_out_q;
    win_en_d     = 1'b0;
    frame_done_d = 1'b0;
    if (accept) begin
      hs_d[0] = {hs_q[0][0], up2};
      hs_d[1] = {hs_q[1][0], up1};
      hs_d[2] = {hs_q[2][0], in_data};
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      // Requiring col>=2 keeps the horizontal taps inside the current row.
      if (row_q >= ROW_MIN && col_q >= COL_MIN) begin
        win_en_d     = 1'b1;
        win_out_d    = win_pack;
        frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
      end
    end
    if (flush) begin
      col_d = '0;
      row_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      win_out_q    <= '0;
      win_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_out_q    <= win_out_d;
      win_en_q     <= win_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    hs_q <= hs_d;
  end

  assign win_out    = win_out_q;
  assign win_en     = win_en_q;
  assign frame_done = frame_done_q;
  assign busy       = (row_q != '0) || (col_q != '0);

endmodule

// File: tb/tb_pe_window_feeder.sv
// tb/tb_pe_window_feeder.sv - directed and random checks of pe_window_feeder against a frame-array model
module tb_pe_window_feeder;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic [71:0] win_out;
  logic        win_en, frame_done, busy;

  always #5 clk = ~clk;

  pe_window_feeder #(.PIX_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .flush      (flush),
    .win_out    (win_out),
    .win_en     (win_en),
    .frame_done (frame_done),
    .busy       (busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0]  img [H][W];
  int          pos = 0;
  logic [71:0] e_win = '0;
  logic        e_en = 1'b0;
  logic        e_fd = 1'b0;

  int          strobes = 0;
  bit          seen_first = 0;
  logic [71:0] first_win = '0;
  logic [71:0] last_win = '0;
  logic        last_fd = 1'b0;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Frame-level reference: pixels land in a 2-D image by raster index.
  task automatic model(input bit v, input logic [7:0] d, input bit f, input bit rst);
    int r, c;
    logic [71:0] w;
    if (rst) begin
      pos = 0; e_win = '0; e_en = 1'b0; e_fd = 1'b0;
    end else if (f) begin
      pos = 0; e_en = 1'b0; e_fd = 1'b0;
    end else if (v) begin
      r = pos / W;
      c = pos % W;
      img[r][c] = d;
      e_en = (r >= 2) && (c >= 2);
      e_fd = e_en && (pos == NPIX - 1);
      if (e_en) begin
        w = '0;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            w = {w[63:0], img[r-2+dr][c-2+dc]};
        e_win = w;
      end
      pos = (pos + 1) % NPIX;
    end else begin
      e_en = 1'b0; e_fd = 1'b0;
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit f, input bit rst);
    @(negedge clk);
    in_valid = v; in_data = d; flush = f; reset = rst;
    @(posedge clk);
    model(v, d, f, rst);
    cyc++;
    #1;
    check_eq("win_en", 72'(win_en), 72'(e_en));
    check_eq("frame_done", 72'(frame_done), 72'(e_fd));
    check_eq("busy", 72'(busy), 72'(pos != 0));
    check_eq("win_out", win_out, e_win);
    if (win_en) begin
      if (!seen_first) first_win = win_out;
      seen_first = 1;
      last_win = win_out;
      last_fd = frame_done;
      strobes++;
    end
  endtask

  task automatic clear_cap();
    strobes = 0; seen_first = 0; first_win = '0; last_win = '0; last_fd = 1'b0;
  endtask

  function automatic logic [7:0] pix_val(input int mode, input logic [7:0] base, input int r, input int c);
    if (mode == 2) return ((r + c) % 2 == 1) ? 8'hFF : 8'h00;
    return 8'(int'(base) + r * 8 + c);
  endfunction

  // mode 0: continuous, 1: bubble every third cycle, 2: checkerboard
  task automatic send_frame(input int mode, input logic [7:0] base);
    int i = 0;
    int k = 0;
    while (i < NPIX) begin
      if (mode == 1 && (k % 3) == 2) begin
        step(1'b0, 8'($urandom), 1'b0, 1'b0);
      end else begin
        step(1'b1, pix_val(mode, base, i / W, i % W), 1'b0, 1'b0);
        i++;
      end
      k++;
    end
  endtask

  task automatic check_ramp(input string tag);
    check_eq({tag, "_count"}, 72'(strobes), 72'd36);
    check_eq({tag, "_first"}, first_win, 72'h000102_08090A_101112);
    check_eq({tag, "_last"}, last_win, 72'h2D2E2F_353637_3D3E3F);
    check_eq({tag, "_last_fd"}, 72'(last_fd), 72'd1);
  endtask

  initial begin
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h55, 1'b0, 1'b1);

    clear_cap();
    send_frame(0, 8'h00);
    check_ramp("ramp");

    step(1'b0, 8'h00, 1'b0, 1'b0);
    clear_cap();
    send_frame(1, 8'h00);
    check_ramp("bubble");

    clear_cap();
    send_frame(0, 8'h00);
    clear_cap();
    send_frame(0, 8'h80);
    check_eq("b2b_count", 72'(strobes), 72'd36);
    check_eq("b2b_first", first_win, 72'h808182_88898A_909192);
    check_eq("b2b_last", last_win, 72'hADAEAF_B5B6B7_BDBEBF);

    for (int i = 0; i <= 8'h1A; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h1B, 1'b1, 1'b0);
    check_eq("flush_en", 72'(win_en), 72'd0);
    check_eq("flush_busy", 72'(busy), 72'd0);
    clear_cap();
    send_frame(0, 8'h00);
    check_ramp("after_flush");

    for (int i = 0; i < 30; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h1E, 1'b0, 1'b1);
    check_eq("rst_win_out", win_out, 72'd0);
    check_eq("rst_busy", 72'(busy), 72'd0);
    clear_cap();
    send_frame(0, 8'h00);
    check_ramp("after_reset");

    clear_cap();
    send_frame(2, 8'h00);
    check_eq("chk_count", 72'(strobes), 72'd36);
    check_eq("chk_first", first_win, 72'h00FF00_FF00FF_00FF00);

    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom),
           $urandom_range(0, 99) == 0, $urandom_range(0, 299) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
